// File: rtl/prio_drain.sv
// prio_drain: accepts a request vector and replays each set bit as a one-hot
// grant beat, highest index first, with its binary index and a last flag.
module prio_drain #(
    parameter int unsigned DW = 8,
    parameter int unsigned IW = 3
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] pending_q, pending_d;

    logic [IW-1:0] top_idx;
    logic [DW-1:0] top_onehot;
    logic          single;

    // Ascending scan so the highest set bit wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < DW; i++) begin
            if (pending_q[i]) begin
                top_idx = IW'(i);
            end
        end
        top_onehot = DW'(1) << top_idx;
        single     = (pending_q & (pending_q - DW'(1))) == '0;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                // An all-zero vector is consumed without producing a beat.
                if (in_valid && (in != '0)) begin
                    pending_d = in;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out       = top_onehot;
                out_idx   = top_idx;
                out_last  = single;
                if (out_ready) begin
                    pending_d = pending_q & ~top_onehot;
                    if (single) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_prio_drain.sv
// Directed bench for prio_drain: inputs change and outputs are sampled on the
// falling clock edge, away from the active rising edge.
module tb_prio_drain;

    logic       clk;
    logic       nreset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    prio_drain #(
        .DW(8),
        .IW(3)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out"}, out, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Offer a vector for one cycle while the block is idle.
    task automatic send_vec(input logic [7:0] v);
        in       = v;
        in_valid = 1'b1;
        check("send_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in       = 8'hA5;
    endtask

    // Check the beat currently presented, accept it, move to the next cycle.
    task automatic expect_beat(input int idx, input logic last);
        logic [7:0] exp_out;
        exp_out   = 8'(1) << idx;
        out_ready = 1'b1;
        check("beat_valid", out_valid, 1);
        check("beat_out", out, exp_out);
        check("beat_idx", out_idx, idx);
        check("beat_last", out_last, last);
        check("beat_in_ready", in_ready, 0);
        check("beat_busy", busy, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] held_out;
        logic [2:0] held_idx;
        logic       held_last;
        int         exp_idx;
        int         handshakes;
        int         cycles;

        nreset    = 1'b0;
        in_valid  = 1'b0;
        in        = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_idx", out_idx, 0);
        check("reset_last", out_last, 0);
        nreset = 1'b1;
        @(negedge clk);

        // Zero vector is consumed and dropped.
        send_vec(8'h00);
        check_idle("zero_vec");
        @(negedge clk);
        check_idle("zero_vec_after");

        // Mixed vector 00110110.
        send_vec(8'b0011_0110);
        expect_beat(5, 1'b0);
        expect_beat(4, 1'b0);
        expect_beat(2, 1'b0);
        expect_beat(1, 1'b1);
        check_idle("mixed_done");

        // Every single-bit vector.
        for (int i = 0; i < 8; i++) begin
            send_vec(8'(1) << i);
            expect_beat(i, 1'b1);
            check_idle("single_done");
        end

        // All ones with pseudo-random back-pressure.
        send_vec(8'hFF);
        exp_idx    = 7;
        handshakes = 0;
        cycles     = 0;
        held_out   = out;
        held_idx   = out_idx;
        held_last  = out_last;
        while (exp_idx >= 0 && cycles < 200) begin
            out_ready = ($urandom_range(0, 2) != 0);
            check("ff_valid", out_valid, 1);
            check("ff_idx", out_idx, exp_idx);
            check("ff_out", out, 32'(8'(1) << exp_idx));
            check("ff_last", out_last, (exp_idx == 0) ? 1 : 0);
            check("ff_stable_out", out, held_out);
            check("ff_stable_idx", out_idx, held_idx);
            check("ff_stable_last", out_last, held_last);
            if (out_ready) begin
                handshakes++;
                exp_idx--;
            end
            @(negedge clk);
            cycles++;
            held_out  = out;
            held_idx  = out_idx;
            held_last = out_last;
        end
        check("ff_no_timeout", (cycles < 200) ? 1 : 0, 1);
        check("ff_handshakes", handshakes, 8);
        check_idle("ff_done");

        // Reset in the middle of a drain.
        out_ready = 1'b0;
        send_vec(8'b1000_0001);
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_idx", out_idx, 7);
        nreset = 1'b0;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check_idle("rst_release");
        send_vec(8'b0000_0100);
        expect_beat(2, 1'b1);
        check_idle("rst_after");

        // Back-to-back vectors with in_valid held high.
        out_ready = 1'b1;
        in        = 8'b1100_0000;
        in_valid  = 1'b1;
        check("b2b_first_ready", in_ready, 1);
        @(negedge clk);
        in = 8'b0000_0011;
        expect_beat(7, 1'b0);
        expect_beat(6, 1'b1);
        check_idle("b2b_bubble");
        @(negedge clk);
        expect_beat(1, 1'b0);
        in_valid = 1'b0;
        expect_beat(0, 1'b1);
        check_idle("b2b_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
